// File: rtl/transmissor_morse.sv
// transmissor_morse: keys a latched 5-symbol Morse code word out serially.
//   Timing in units of UNIT_CYCLES clocks: dot = 1, dash = 3,
//   gap between symbols = 1, gap after the character = 3.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset
//   ready  - code word strobe; accepted only in IDLE
//   m1..m5 - symbols, m1 sent first; 1 = dash, 0 = dot
//   key    - registered tone output
//   busy   - word in flight; ready ignored
//   done   - one-cycle pulse on the IDLE cycle that ends a word
module transmissor_morse #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ready,
  input  logic m1,
  input  logic m2,
  input  logic m3,
  input  logic m4,
  input  logic m5,
  output logic key,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(3*UNIT_CYCLES+1);
  // Counters hold "cycles remaining minus one" so a load of N-1 yields N cycles.
  localparam logic [CW-1:0] UNIT_N = CW'(UNIT_CYCLES-1);
  localparam logic [CW-1:0] TRIP_N = CW'(3*UNIT_CYCLES-1);

  typedef enum logic [1:0] {IDLE, MARK, GAP_SYM, GAP_CHAR} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [4:0]      word;   // word[4] = m1 ... word[0] = m5
  logic [2:0]      nidx;

  assign nidx = idx + 3'd1;

  function automatic logic [CW-1:0] mark_len(input logic dash);
    return dash ? TRIP_N : UNIT_N;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      word  <= '0;
      key   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ready) begin
            word  <= {m1, m2, m3, m4, m5};
            idx   <= '0;
            cnt   <= mark_len(m1);
            key   <= 1'b1;
            busy  <= 1'b1;
            state <= MARK;
          end
        end
        MARK: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            key <= 1'b0;
            if (idx < 3'd4) begin
              cnt   <= UNIT_N;
              state <= GAP_SYM;
            end else begin
              cnt   <= TRIP_N;
              state <= GAP_CHAR;
            end
          end
        end
        GAP_SYM: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            idx   <= nidx;
            cnt   <= mark_len(word[3'd4 - nidx]);
            key   <= 1'b1;
            state <= MARK;
          end
        end
        GAP_CHAR: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // busy drops and done rises together, so the two never overlap
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transmissor_morse.sv
// tb_transmissor_morse: directed bench for transmissor_morse at UNIT_CYCLES=2.
// Expected per-cycle {key,busy,done} streams are built from the Morse timing
// rules and compared after each rising edge.
module tb_transmissor_morse;

  localparam int U = 2;

  logic clk = 1'b0;
  logic reset, ready, m1, m2, m3, m4, m5;
  logic key, busy, done;

  int checks = 0;
  int failures = 0;
  logic [2:0] expq[$];

  transmissor_morse #(.UNIT_CYCLES(U)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5),
    .key(key), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input logic [4:0] w);
    {m1, m2, m3, m4, m5} = w;
  endtask

  // expected {key,busy,done} from the accepting edge through the done cycle
  task automatic build(input logic [4:0] w);
    expq.delete();
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < (w[4-i] ? 3*U : U); c++) expq.push_back(3'b110);
      if (i < 4) for (int c = 0; c < U; c++) expq.push_back(3'b010);
    end
    for (int c = 0; c < 3*U; c++) expq.push_back(3'b010);
    expq.push_back(3'b001);
  endtask

  // Present w with ready=1, then check n cycles (n=0 means the whole word).
  // hold keeps ready high afterwards; disturb injects ignored traffic mid-word.
  task automatic send(input string name, input logic [4:0] w, input logic hold,
                      input logic disturb, input int n, input int exp_busy);
    int nb, nd, len;
    nb = 0; nd = 0;
    build(w);
    len = (n == 0) ? expq.size() : n;
    set_m(w);
    ready = 1'b1;
    for (int k = 0; k < len; k++) begin
      step();
      chk($sformatf("%s[%0d]", name, k), {29'd0, key, busy, done}, {29'd0, expq[k]});
      nb += int'(busy);
      nd += int'(done);
      ready = hold;
      if (disturb) begin
        if (k == 9) begin
          ready = 1'b1;
          set_m(5'b00000);
        end else if (k > 9 && k < 20) begin
          ready = 1'($urandom_range(0, 1));
          set_m(5'($urandom));
        end
      end
    end
    if (n == 0) begin
      chk({name, "_busy_len"}, nb, exp_busy);
      chk({name, "_done_cnt"}, nd, 1);
    end
  endtask

  task automatic idle_check(input string name);
    ready = 1'b0;
    step();
    chk(name, {29'd0, key, busy, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; ready = 1'b1; set_m(5'b11111);
    step(); chk("rst0", {29'd0, key, busy, done}, 32'd0);
    step(); chk("rst1", {29'd0, key, busy, done}, 32'd0);
    reset = 1'b1; ready = 1'b0;
    idle_check("rst_rel");

    send("d0", 5'b11111, 1'b0, 1'b0, 0, 22*U);
    idle_check("d0_idle");
    send("d1", 5'b01111, 1'b0, 1'b0, 0, 20*U);
    idle_check("d1_idle");
    send("d5", 5'b00000, 1'b0, 1'b0, 0, 12*U);
    idle_check("d5_idle");
    send("ign", 5'b11111, 1'b0, 1'b1, 0, 22*U);
    idle_check("ign_idle");

    // ready held high: the done cycle accepts the next word directly
    send("b2b_a", 5'b00001, 1'b1, 1'b0, 0, 14*U);
    send("b2b_b", 5'b00001, 1'b1, 1'b0, 0, 14*U);
    send("abort", 5'b00001, 1'b1, 1'b0, 15, 0);
    ready = 1'b0;
    reset = 1'b0;
    step(); chk("abort_rst", {29'd0, key, busy, done}, 32'd0);
    reset = 1'b1;
    step(); chk("abort_nodone0", {29'd0, key, busy, done}, 32'd0);
    step(); chk("abort_nodone1", {29'd0, key, busy, done}, 32'd0);

    // a fresh word still works after the abort
    send("post", 5'b10000, 1'b0, 1'b0, 0, 14*U);
    idle_check("post_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
